// File: rtl/des_pkg.sv
// Shared DES constants for the decryption core: permutation tables, S-box contents,
// decrypt-order key rotations, control-state encoding and small bit-shuffling helpers.
package des_pkg;

  localparam int RND_W = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ROUND = ST_ROUND,
    S_DONE  = ST_DONE
  } des_state_e;

  // Tables use DES numbering: entry value n names DES bit n (bit 1 = MSB).
  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Right-rotation per decrypt round; round 1 reuses C0/D0 since encryption rotates a full 28.
  localparam logic [1:0] ROT_TBL [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // One 256-bit word per S-box: row-major, entry (row 0, col 0) in the top nibble.
  localparam logic [255:0] SBOX_TBL [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[i])];
    return y;
  endfunction

  function automatic logic [47:0] e_perm(input logic [31:0] x);
    logic [47:0] y;
    y = 48'd0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[i])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = 32'd0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[i])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = 56'd0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[i])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = 48'd0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[i])];
    return y;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] y;
    case (n)
      2'd1:    y = {x[0], x[27:1]};
      2'd2:    y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

  // Outer bits select the row, inner four bits the column.
  function automatic logic [3:0] sbox_lookup(input logic [255:0] tbl, input logic [5:0] x);
    logic [5:0]   n;
    logic [255:0] t;
    n = {x[5], x[0], x[4:1]};
    t = tbl >> {6'd63 - n, 2'b00};
    return t[3:0];
  endfunction

  function automatic logic key_parity_err(input logic [63:0] k);
    return (~^k[63:56]) | (~^k[55:48]) | (~^k[47:40]) | (~^k[39:32]) |
           (~^k[31:24]) | (~^k[23:16]) | (~^k[15:8])  | (~^k[7:0]);
  endfunction

endpackage

// File: rtl/des_round_f.sv
// DES Feistel function f(R, K): expand, mix with the round key, substitute, permute.
module des_round_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);

  logic [47:0] x;
  logic [31:0] s;

  assign x = e_perm(r) ^ k;

  SBox1 u_sbox1 (.din(x[47:42]), .dout(s[31:28]));
  SBox2 u_sbox2 (.din(x[41:36]), .dout(s[27:24]));
  SBox3 u_sbox3 (.din(x[35:30]), .dout(s[23:20]));
  SBox4 u_sbox4 (.din(x[29:24]), .dout(s[19:16]));
  SBox5 u_sbox5 (.din(x[23:18]), .dout(s[15:12]));
  SBox6 u_sbox6 (.din(x[17:12]), .dout(s[11:8]));
  SBox7 u_sbox7 (.din(x[11:6]),  .dout(s[7:4]));
  SBox8 u_sbox8 (.din(x[5:0]),   .dout(s[3:0]));

  assign f = p_perm(s);

endmodule

// File: rtl/des_sbox.sv
// The eight DES substitution boxes SBox1..SBox8: 6-bit input (MSB = first DES bit), 4-bit output.
module SBox1 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = sbox_lookup(SBOX_TBL[0], din);
endmodule

module SBox2 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = sbox_lookup(SBOX_TBL[1], din);
endmodule

module SBox3 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = sbox_lookup(SBOX_TBL[2], din);
endmodule

module SBox4 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = sbox_lookup(SBOX_TBL[3], din);
endmodule

module SBox5 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = sbox_lookup(SBOX_TBL[4], din);
endmodule

module SBox6 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = sbox_lookup(SBOX_TBL[5], din);
endmodule

module SBox7 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = sbox_lookup(SBOX_TBL[6], din);
endmodule

module SBox8 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = sbox_lookup(SBOX_TBL[7], din);
endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption, one Feistel round per clock with the key schedule run backwards.
// Optional key-byte odd-parity reporting on key_err is built when DES_KEY_PARITY_CHECK_EN is defined.
module des_decrypt_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        key_err
);

  des_state_e       state_q, state_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [31:0]      l_q, l_d, r_q, r_d;
  logic [27:0]      c_q, c_d, d_q, d_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_data_q, out_data_d;

  logic             accept;
  logic [1:0]       rot_amt;
  logic [27:0]      c_rot, d_rot;
  logic [47:0]      round_key;
  logic [31:0]      f_out;

  assign accept    = in_valid & in_ready_q;
  assign rot_amt   = ROT_TBL[rnd_q[3:0] - 4'd1];
  assign c_rot     = rotr28(c_q, rot_amt);
  assign d_rot     = rotr28(d_q, rot_amt);
  assign round_key = pc2_perm({c_rot, d_rot});

  des_round_f u_round_f (
    .r (r_q),
    .k (round_key),
    .f (f_out)
  );

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    in_ready_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          {l_d, r_d} = ip_perm(in_data);
          {c_d, d_d} = pc1_perm(in_key);
          rnd_d      = 5'd1;
          state_d    = S_ROUND;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_ROUND: begin
        c_d   = c_rot;
        d_d   = d_rot;
        l_d   = r_q;
        r_d   = l_q ^ f_out;
        rnd_d = rnd_q + 5'd1;
        if (rnd_q == 5'd16) begin
          // Halves are swapped back before the final permutation.
          out_data_d  = fp_perm({r_d, l_d});
          out_valid_d = 1'b1;
          rnd_d       = 5'd0;
          state_d     = S_DONE;
        end else begin
          state_d     = S_ROUND;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d     = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rnd_q       <= 5'd0;
      l_q         <= 32'd0;
      r_q         <= 32'd0;
      c_q         <= 28'd0;
      d_q         <= 28'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic par_err_q, par_err_d;
  logic key_err_q, key_err_d;
  logic finish, release_out;

  assign finish      = (state_q == S_ROUND) && (rnd_q == 5'd16);
  assign release_out = (state_q == S_DONE) && out_ready;

  // Parity is captured with the key and only shown once the plaintext is presented.
  always_comb begin
    par_err_d = par_err_q;
    key_err_d = key_err_q;
    if (accept) begin
      par_err_d = key_parity_err(in_key);
    end else begin
      par_err_d = par_err_q;
    end
    if (finish) begin
      key_err_d = par_err_q;
    end else if (release_out) begin
      key_err_d = 1'b0;
    end else begin
      key_err_d = key_err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
      key_err_q <= key_err_d;
    end
  end

  assign key_err = key_err_q;
`else
  assign key_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core: known-answer vectors, backpressure, mid-block reset
// and back-to-back accepts, checked through an expected-result queue.
module tb_des_decrypt_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        key_err;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q [$];
  int   acc_q [$];
  int   cyc      = 0;
  int   last_acc = 0;
  int   prev_acc = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT_A    = 64'h85E813540F0AB405;
  localparam logic [63:0] PT_A    = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY_B   = 64'h0E329232EA6D0D73;
  localparam logic [63:0] CT_B    = 64'h0000000000000000;
  localparam logic [63:0] PT_B    = 64'h8787878787878787;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;
`ifdef DES_KEY_PARITY_CHECK_EN
  localparam logic ERR_BAD = 1'b1;
`else
  localparam logic ERR_BAD = 1'b0;
`endif

  always #5 clk = ~clk;

  des_decrypt_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .key_err   (key_err)
  );

  task automatic tick();
    logic acc;
    acc = in_valid & in_ready & rst_n;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      acc_q.push_back(cyc);
      prev_acc = last_acc;
      last_acc = cyc;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] ct, input logic [63:0] key, input logic [63:0] pt,
                      input logic err, input bit track);
    int n;
    n        = 0;
    in_data  = ct;
    in_key   = key;
    in_valid = 1'b1;
    if (track) sb_q.push_back(exp_t'{data: pt, err: err});
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check("accept_wait", 64'(n < 40), 64'd1);
    tick();
    in_valid = 1'b0;
    in_data  = ~ct;
    in_key   = ~key;
  endtask

  task automatic collect(input string tag);
    int   n;
    int   acc;
    exp_t e;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sb_entry"}, 64'(sb_q.size() > 0), 64'd1);
    e   = (sb_q.size() > 0) ? sb_q.pop_front() : exp_t'{data: 64'd0, err: 1'b0};
    acc = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
    check({tag, "_data"}, out_data, e.data);
    check({tag, "_key_err"}, 64'(key_err), 64'(e.err));
    check({tag, "_latency"}, 64'(cyc - acc), 64'd16);
    if (out_ready) begin
      tick();
      check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
      check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 64'd0;
    in_key    = 64'd0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_key_err", 64'(key_err), 64'd0);
    rst_n = 1'b1;
    tick();

    send(CT_A, KEY_A, PT_A, 1'b0, 1'b1);
    check("busy_in_ready", 64'(in_ready), 64'd0);
    collect("kat_a");

    send(CT_B, KEY_B, PT_B, 1'b0, 1'b1);
    collect("kat_b");

    send(CT_A, KEY_BAD, PT_A, ERR_BAD, 1'b1);
    collect("bad_parity");

    out_ready = 1'b0;
    send(CT_A, KEY_A, PT_A, 1'b0, 1'b1);
    collect("bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = CT_B;
      in_key   = KEY_B;
      tick();
      check("bp_data_hold", out_data, PT_A);
      check("bp_valid_hold", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("bp_ignored_input", 64'(seen), 64'd0);
    check("bp_no_accept", 64'(acc_q.size()), 64'd0);

    send(CT_B, KEY_B, PT_B, 1'b0, 1'b0);
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_data", out_data, 64'd0);
    check("abort_key_err", 64'(key_err), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    acc_q.delete();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_output", 64'(seen), 64'd0);
    send(CT_A, KEY_A, PT_A, 1'b0, 1'b1);
    collect("after_abort");

    in_data  = CT_A;
    in_key   = KEY_A;
    in_valid = 1'b1;
    sb_q.push_back(exp_t'{data: PT_A, err: 1'b0});
    sb_q.push_back(exp_t'{data: PT_B, err: 1'b0});
    tick();
    in_data = CT_B;
    in_key  = KEY_B;
    collect("b2b_first");
    tick();
    in_valid = 1'b0;
    collect("b2b_second");
    check("b2b_spacing", 64'(last_acc - prev_acc), 64'd18);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
